// File: rtl/scan_xfer_pkg.sv
// Shared definitions for the scanner transfer link: receiver state encoding,
// default sample width and handshake constants common to both link ends.
package scan_xfer_pkg;

    localparam int XFER_DATA_W            = 8;
    // Cycles from request seen to grant driven, and the minimum request-low
    // gap required before a new burst may start.
    localparam int XFER_GRANT_LATENCY     = 1;
    localparam int XFER_REARM_IDLE_CYCLES = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        DONE = 2'd2
    } xfer_state_e;

endpackage

// File: rtl/scan_xfer_fifo.sv
// Synchronous single-clock FIFO with registered read data, a one-cycle read
// strobe and an occupancy output from which full/empty are derived.
module scan_xfer_fifo
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     rd_en,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     rd_valid,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              push;
    logic              pop;

    assign full  = (level == LW'(DEPTH));
    assign empty = (level == '0);
    assign pop   = rd_en && !empty;
    // A write into a full FIFO is only legal when a pop frees the slot in the same cycle.
    assign push  = wr_en && (!full || pop);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= pop;
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr  <= rd_ptr + AW'(1);
                rd_data <= mem[rd_ptr];
            end
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/scan_xfer_receiver.sv
// Station side of the scanner transfer link: grants the link, buffers the
// burst in a local FIFO and counts accepted bytes for the hex display path.
module scan_xfer_receiver
    import scan_xfer_pkg::*;
#(
    parameter int DATA_W = XFER_DATA_W,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     xfer_req,
    output logic                     xfer_ack,
    input  logic                     xfer_valid,
    input  logic [DATA_W-1:0]        xfer_data,
    input  logic                     xfer_last,
    input  logic                     rd_en,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     rd_valid,
    output logic [$clog2(DEPTH):0]   buf_level,
    output logic [CNT_W-1:0]         data_count,
    output logic                     overflow,
    output logic                     busy
);

    xfer_state_e state;
    xfer_state_e state_next;

    logic fifo_full;
    logic fifo_empty;
    logic pop_ok;
    logic byte_in;
    logic wr_ok;
    logic drop;

    // A byte is only taken while granted and while the scanner still requests;
    // the abort cycle (request low) never captures data.
    assign pop_ok  = rd_en && !fifo_empty;
    assign byte_in = (state == RECV) && xfer_req && xfer_valid;
    assign wr_ok   = byte_in && (!fifo_full || pop_ok);
    assign drop    = byte_in && fifo_full && !pop_ok;
    assign busy    = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (xfer_req && !fifo_full) begin
                    state_next = RECV;
                end
            end
            RECV: begin
                if (!xfer_req) begin
                    state_next = DONE;
                end else if (xfer_valid && xfer_last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                // A held request must be released before the next burst.
                if (!xfer_req) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            xfer_ack   <= 1'b0;
            data_count <= '0;
            overflow   <= 1'b0;
        end else begin
            xfer_ack <= (state_next == RECV);
            if (wr_ok) begin
                data_count <= data_count + CNT_W'(1);
            end
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    scan_xfer_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_ok),
        .wr_data  (xfer_data),
        .rd_en    (rd_en),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .level    (buf_level),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

endmodule
